dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder serving the CPU's MEM-stage load/store requests. It replaces the single-cycle data memory with a wait-state model of slower backing storage. The block holds each request for a parameterised number of wait cycles and freezes the pipeline with `stall_o` while the access is outstanding. It then completes the access with a one-cycle `ack_o` pulse and registered read data.

## Interface

Parameters:
- `DEPTH`, default 256: number of 32-bit words; power of two, 4..65536.
- `LATENCY`, default 3: wait cycles between acceptance and completion; 0..15.

Ports:
- `clk_i` in 1: single clock; all state updates on its rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `req_i` in 1: access request from the EX/MEM register (MemRead | MemWrite).
- `we_i` in 1: 1 = store, 0 = load; sampled with `req_i`.
- `addr_i` in 32: byte address (ALU result).
- `wdata_i` in 32: store data.
- `stall_o` out 1: freeze PC, IF/ID, ID/EX and EX/MEM while high.
- `ack_o` out 1: one-cycle completion pulse.
- `rdata_o` out 32: load data; valid while `ack_o` is high, held afterwards.
- `err_o` out 1: access error, qualified by `ack_o`. Present only with `DMEM_ADDR_CHECK_EN`.

## Operation

- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If `req_i` = 1, the request is accepted. `addr_i`, `we_i` and `wdata_i` are captured.
  - Next state is WAIT with counter = `LATENCY`-1. If `LATENCY` = 0, next state is RESP.
- WAIT:
  - The counter decrements each cycle.
  - When the counter = 0, the access is performed and the next state is RESP.
  - Inputs are ignored in WAIT; only the captured values are used.
- The access is performed at the clock edge that enters RESP:
  - Store: writes `mem[widx]` = captured wdata. `rdata_o` is unchanged.
  - Load: registers `rdata_o` = `mem[widx]`.
  - `widx` = captured addr[log2(DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH*4.
  - addr[1:0] is ignored.
- RESP:
  - `ack_o` = 1 and `stall_o` = 0, so the pipeline advances at this edge.
  - `req_i` in RESP belongs to the completing instruction and is not accepted.
  - Next state is always IDLE.
- `stall_o` = (state==IDLE & `req_i`) | (state==WAIT). It is combinational on `req_i` in IDLE, so the requesting instruction never leaves MEM before `ack_o`.
- Back-to-back requests are served at one access per `LATENCY`+2 cycles.
- Reset:
  - While `rst_i` = 0 at an edge: state = IDLE, counter = 0, `rdata_o` = 0, `err_o` = 0.
  - `ack_o` = 0 and `stall_o` = 0 are forced combinationally during the reset cycle.
  - Memory contents are not reset.
- Reset before the RESP edge aborts the access. A pending store is not written and no `ack_o` is issued.

## Timing

- Request high in IDLE at cycle N gives `stall_o` high in cycles N..N+`LATENCY` and `ack_o` in cycle N+`LATENCY`+1.
- `LATENCY` = 0: `stall_o` high in cycle N only; `ack_o` in cycle N+1.
- `rdata_o` and `err_o` are registered and change only at the RESP-entry edge or at reset.
- No combinational path exists from `addr_i`/`wdata_i` to any output.

## Configuration

- `DMEM_ADDR_CHECK_EN` defined:
  - `err_o` exists.
  - An access is an error if captured addr[1:0] != 0 or addr[31:log2(DEPTH)+2] != 0.
  - On an error the store is suppressed, a load returns `rdata_o` = 0, and `err_o` = 1 in the RESP cycle.
  - `err_o` = 0 on every non-error completion.
  - Latency is unchanged.
- Not defined: no `err_o` port, no checking; wrap and ignore-low-bits behaviour applies.

## Structure

- Package `dmem_pkg`:
  - `dmem_state_t` enum (IDLE, WAIT, RESP).
  - `DATA_W` = 32.
  - `LAT_W` = 4 (counter width).
  - Function `widx_w(DEPTH)`.
- Sub-module `dmem_array`: synchronous single-port word RAM (`DEPTH` x 32, write-enable, registered read). The FSM and stall/ack logic stay in `dmem_responder`.

## Test plan

1. Reset: `rst_i` = 0 for 2 cycles with `req_i` = 1 -> `stall_o` = 0, `ack_o` = 0, `rdata_o` = 0, then state IDLE.
2. `LATENCY` = 3: store 0xDEADBEEF to 0x10 at cycle N, then load 0x10 -> each access has `stall_o` high for 4 cycles; `ack_o` at N+4 and N+9; load `rdata_o` = 0xDEADBEEF.
3. `LATENCY` = 0: three back-to-back loads of preloaded words 0x1, 0x2, 0x3 -> `ack_o` every 2nd cycle, data in order, `stall_o` one cycle per access.
4. Store 0x11111111 to 0x20, then store 0x22222222 to 0x20 with reset asserted in the second WAIT cycle, then load 0x20 -> returns 0x11111111; no `ack_o` for the aborted store.
5. Macro off, `DEPTH` = 256: store 0xCAFEF00D to 0x400, load 0x000 -> 0xCAFEF00D. Macro on: the same store gives `err_o` = 1, the load returns the prior value of 0x000 with `err_o` = 0.
6. Macro on: load 0x13 -> `ack_o` with `err_o` = 1, `rdata_o` = 0; an aligned load after it -> `err_o` = 0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
package dmem_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned LAT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   // Request fields captured at acceptance and replayed when the access is performed
   typedef struct packed {
      logic              we;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } dmem_req_t;

   function automatic int unsigned widx_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store bus between the pipeline (master) and the responder (slave).
// err_o exists only when DMEM_ADDR_CHECK_EN is defined.
interface dmem_responder_if;
   import dmem_pkg::*;

   logic              req_i;
   logic              we_i;
   logic [DATA_W-1:0] addr_i;
   logic [DATA_W-1:0] wdata_i;
   logic              stall_o;
   logic              ack_o;
   logic [DATA_W-1:0] rdata_o;
`ifdef DMEM_ADDR_CHECK_EN
   logic              err_o;

   modport master (output req_i, we_i, addr_i, wdata_i,
                   input  stall_o, ack_o, rdata_o, err_o);
   modport slave  (input  req_i, we_i, addr_i, wdata_i,
                   output stall_o, ack_o, rdata_o, err_o);
`else
   modport master (output req_i, we_i, addr_i, wdata_i,
                   input  stall_o, ack_o, rdata_o);
   modport slave  (input  req_i, we_i, addr_i, wdata_i,
                   output stall_o, ack_o, rdata_o);
`endif

endinterface

// File: rtl/dmem_responder_array.sv
// Single-port DEPTH x 32 word RAM with registered read; the read register
// holds its value between loads and can be cleared for rejected loads.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              we,
   input  logic              clr,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (clr) begin
         rdata <= '0;
      end else if (en && !we) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: holds each MEM-stage access for LATENCY wait
// cycles under stall, then acks. Optional address checking via DMEM_ADDR_CHECK_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   dmem_responder_if.slave  bus
);

   localparam int unsigned    AW       = widx_w(DEPTH);
   localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

   dmem_state_t      state;
   logic [LAT_W-1:0] cnt;
   dmem_req_t        req_q;
   dmem_req_t        acc;
   logic             acc_en;
   logic             acc_ok;

   // With LATENCY = 0 the access happens at the accept edge, so use live inputs there
   always_comb begin
      acc = req_q;
      if (state == IDLE) begin
         acc.we    = bus.we_i;
         acc.addr  = bus.addr_i;
         acc.wdata = bus.wdata_i;
      end
      acc_en = rst_i && (((state == IDLE) && bus.req_i && (LATENCY == 0)) ||
                         ((state == WAIT) && (cnt == '0)));
   end

`ifdef DMEM_ADDR_CHECK_EN
   logic err_q;

   assign acc_ok = (acc.addr[1:0] == 2'b00) && (acc.addr[DATA_W-1:AW+2] == '0);

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         err_q <= 1'b0;
      end else if (acc_en) begin
         err_q <= !acc_ok;
      end
   end

   assign bus.err_o = err_q;
`else
   logic unused_addr_bits;

   assign acc_ok           = 1'b1;
   assign unused_addr_bits = ^{acc.addr[DATA_W-1:AW+2], acc.addr[1:0]};
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_i) begin
                  req_q.we    <= bus.we_i;
                  req_q.addr  <= bus.addr_i;
                  req_q.wdata <= bus.wdata_i;
                  if (LATENCY == 0) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Stall covers the request cycle itself so the instruction cannot leave MEM early
   assign bus.stall_o = rst_i && (((state == IDLE) && bus.req_i) || (state == WAIT));
   assign bus.ack_o   = rst_i && (state == RESP);

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk_i),
      .rst_n (rst_i),
      .en    (acc_en),
      .we    (acc.we && acc_ok),
      .clr   (!acc.we && !acc_ok),
      .addr  (acc.addr[AW+1:2]),
      .wdata (acc.wdata),
      .rdata (bus.rdata_o)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=3 instance (a) and LATENCY=0 instance (b).
// Expected values adapt to DMEM_ADDR_CHECK_EN.
module tb_dmem_responder;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   dmem_responder_if ia ();
   dmem_responder_if ib ();

   dmem_responder #(.DEPTH(256), .LATENCY(3)) u_dut_a (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (ia)
   );

   dmem_responder #(.DEPTH(256), .LATENCY(0)) u_dut_b (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (ib)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic req, input logic we,
                        input logic [31:0] a, input logic [31:0] d);
      if (sel == 0) begin
         ia.req_i = req; ia.we_i = we; ia.addr_i = a; ia.wdata_i = d;
      end else begin
         ib.req_i = req; ib.we_i = we; ib.addr_i = a; ib.wdata_i = d;
      end
   endtask

   function automatic logic get_stall(input int sel);
      return (sel == 0) ? ia.stall_o : ib.stall_o;
   endfunction

   function automatic logic get_ack(input int sel);
      return (sel == 0) ? ia.ack_o : ib.ack_o;
   endfunction

   function automatic logic [31:0] get_rdata(input int sel);
      return (sel == 0) ? ia.rdata_o : ib.rdata_o;
   endfunction

`ifdef DMEM_ADDR_CHECK_EN
   function automatic logic get_err(input int sel);
      return (sel == 0) ? ia.err_o : ib.err_o;
   endfunction
`endif

   // Starts at a negedge in IDLE; returns at the negedge after the ack cycle
   task automatic access(input int sel, input int lat, input logic we,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err, input string tag);
      drive(sel, 1'b1, we, a, d);
      #1;
      chk({tag, " stall req"}, 32'(get_stall(sel)), 32'd1);
      chk({tag, " ack req"},   32'(get_ack(sel)),   32'd0);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         drive(sel, 1'b1, ~we, ~a, ~d);
         #1;
         chk({tag, " stall wait"}, 32'(get_stall(sel)), 32'd1);
         chk({tag, " ack wait"},   32'(get_ack(sel)),   32'd0);
      end
      @(negedge clk);
      drive(sel, 1'b1, we, a, d);
      #1;
      chk({tag, " stall resp"}, 32'(get_stall(sel)), 32'd0);
      chk({tag, " ack resp"},   32'(get_ack(sel)),   32'd1);
      chk({tag, " rdata"},      get_rdata(sel),      exp_rd);
`ifdef DMEM_ADDR_CHECK_EN
      chk({tag, " err"},        32'(get_err(sel)),   32'(exp_err));
`endif
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (n) begin
         #1;
         chk("idle stall a", 32'(ia.stall_o), 32'd0);
         chk("idle ack a",   32'(ia.ack_o),   32'd0);
         chk("idle stall b", 32'(ib.stall_o), 32'd0);
         chk("idle ack b",   32'(ib.ack_o),   32'd0);
         @(negedge clk);
      end
   endtask

   initial begin
      // Reset held two cycles with a pending request on both instances
      rst_n = 1'b0;
      drive(0, 1'b1, 1'b1, 32'h10, 32'h1234_5678);
      drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         #1;
         chk("rst stall a", 32'(ia.stall_o), 32'd0);
         chk("rst ack a",   32'(ia.ack_o),   32'd0);
         chk("rst rdata a", ia.rdata_o,      32'h0);
         chk("rst stall b", 32'(ib.stall_o), 32'd0);
         chk("rst rdata b", ib.rdata_o,      32'h0);
`ifdef DMEM_ADDR_CHECK_EN
         chk("rst err a",   32'(ia.err_o),   32'd0);
`endif
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // LATENCY=3 store then back-to-back load
      access(0, 3, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, "t2 store");
      access(0, 3, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, "t2 load");
      idle(1);

      // LATENCY=0 preload then three back-to-back loads
      access(1, 0, 1'b1, 32'h0, 32'h1, 32'h0, 1'b0, "t3 st0");
      access(1, 0, 1'b1, 32'h4, 32'h2, 32'h0, 1'b0, "t3 st1");
      access(1, 0, 1'b1, 32'h8, 32'h3, 32'h0, 1'b0, "t3 st2");
      access(1, 0, 1'b0, 32'h0, 32'h0, 32'h1, 1'b0, "t3 ld0");
      access(1, 0, 1'b0, 32'h4, 32'h0, 32'h2, 1'b0, "t3 ld1");
      access(1, 0, 1'b0, 32'h8, 32'h0, 32'h3, 1'b0, "t3 ld2");
      idle(1);

      // Store aborted by reset in its second WAIT cycle
      access(0, 3, 1'b1, 32'h20, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0, "t4 st1");
      drive(0, 1'b1, 1'b1, 32'h20, 32'h2222_2222);
      #1;
      chk("t4 st2 stall req", 32'(ia.stall_o), 32'd1);
      @(negedge clk);
      #1;
      chk("t4 st2 stall w1", 32'(ia.stall_o), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t4 rst stall", 32'(ia.stall_o), 32'd0);
      chk("t4 rst ack",   32'(ia.ack_o),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("t4 post ack",   32'(ia.ack_o), 32'd0);
      chk("t4 post rdata", ia.rdata_o,    32'h0);
      @(negedge clk);
      idle(3);
      access(0, 3, 1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0, "t4 load");
      idle(1);

      // Out-of-range store: wraps to word 0, or is rejected with address checking
      access(0, 3, 1'b1, 32'h000, 32'h5A5A_5A5A, 32'h1111_1111, 1'b0, "t5 pre");
      access(0, 3, 1'b1, 32'h400, 32'hCAFE_F00D, 32'h1111_1111, 1'b1, "t5 store");
`ifdef DMEM_ADDR_CHECK_EN
      access(0, 3, 1'b0, 32'h000, 32'h0, 32'h5A5A_5A5A, 1'b0, "t5 load");
`else
      access(0, 3, 1'b0, 32'h000, 32'h0, 32'hCAFE_F00D, 1'b0, "t5 load");
`endif
      idle(1);

      // Misaligned load, then aligned load
`ifdef DMEM_ADDR_CHECK_EN
      access(0, 3, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, "t6 misaligned");
`else
      access(0, 3, 1'b0, 32'h13, 32'h0, 32'hDEAD_BEEF, 1'b0, "t6 misaligned");
`endif
      access(0, 3, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "t6 aligned");
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
